// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if : EX-stage <-> MDU request/response bundle.
//
// Signals
//   operand1  [31:0]  rs value (dividend / multiplicand / MTHI-MTLO source)
//   operand2  [31:0]  rt value (divisor / multiplier)
//   operation [3:0]   operation code (NONE, MFHI, MFLO, MTHI, MTLO, MULT, ...)
//   start             one-cycle request strobe
//   busy              MDU has an operation in flight
//   dataRead  [31:0]  MFHI/MFLO read data (combinational)
//   hi, lo    [31:0]  architectural HI/LO registers (debug/trace)
//
// Modports
//   master : EX side, drives the request and observes the response.
//   slave  : MDU side, consumes the request and drives the response.
// -----------------------------------------------------------------------------
interface mdu_if;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  operation;
    logic        start;
    logic        busy;
    logic [31:0] dataRead;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output operand1, operand2, operation, start,
        input  busy, dataRead, hi, lo
    );

    modport slave (
        input  operand1, operand2, operation, start,
        output busy, dataRead, hi, lo
    );
endinterface

// File: rtl/mdu_iterative_core.sv
// -----------------------------------------------------------------------------
// mdu_iterative_core : multi-cycle multiply/divide unit owning HI/LO.
//
// The result of a MULT/DIV-class request is computed from the operands and
// HI/LO sampled at the start edge and held as a pending value; HI/LO are
// updated only when the busy window of MUL_CYCLES / DIV_CYCLES expires.
//
// Ports
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : mdu_if.slave -- operands, operation, start in; busy, dataRead,
//            hi, lo out
//
// Parameters
//   MUL_CYCLES : busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (>= 1)
//   DIV_CYCLES : busy cycles for DIV/DIVU (>= 1)
// -----------------------------------------------------------------------------
module mdu_iterative_core #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic  clock,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int CNT_W = 16;

    localparam logic [3:0] OP_MFHI  = 4'd1;
    localparam logic [3:0] OP_MFLO  = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd3;
    localparam logic [3:0] OP_MTLO  = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_MULTU = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        pend_q, pend_d;
    logic               pend_wr_q, pend_wr_d;

    // Multiply / multiply-accumulate. Accumulation wraps modulo 2^64.
    function automatic logic [63:0] mul_result(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [63:0] acc
    );
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        logic        [63:0] prod;
        logic        [63:0] res;
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'd0, a} * {32'd0, b};
        case (op)
            OP_MULT, OP_MADD, OP_MSUB: prod = sprod;
            default:                   prod = uprod;
        endcase
        case (op)
            OP_MULT, OP_MULTU: res = prod;
            OP_MADD, OP_MADDU: res = acc + prod;
            default:           res = acc - prod;
        endcase
        return res;
    endfunction

    // Division on magnitudes, then sign fix-up: quotient truncates toward
    // zero, remainder follows the dividend. Working on magnitudes makes
    // 0x80000000 / -1 fall out naturally as quotient 0x80000000, remainder 0.
    // Returns {remainder, quotient}. A zero divisor is forced to 1 only to
    // keep the arithmetic defined; the caller discards that result.
    function automatic logic [63:0] div_result(
        input logic        is_signed,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] ma, mb, q, r;
        logic        neg_q, neg_r;
        neg_r = is_signed & a[31];
        neg_q = is_signed & (a[31] ^ b[31]);
        ma    = neg_r ? (32'd0 - a) : a;
        mb    = (is_signed & b[31]) ? (32'd0 - b) : b;
        if (mb == 32'd0) mb = 32'd1;
        q     = ma / mb;
        r     = ma % mb;
        q     = neg_q ? (32'd0 - q) : q;
        r     = neg_r ? (32'd0 - r) : r;
        return {r, q};
    endfunction

    // Next-state / datapath decision
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.operation)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            pend_d    = mul_result(bus.operation, bus.operand1,
                                                   bus.operand2, {hi_q, lo_q});
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MUL_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d    = div_result(bus.operation == OP_DIV,
                                                   bus.operand1, bus.operand2);
                            // Divide-by-zero still burns the full latency but
                            // leaves HI/LO untouched.
                            pend_wr_d = (bus.operand2 != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = bus.operand1;
                        OP_MTLO: lo_d = bus.operand1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving while running are ignored outright.
                if (cnt_q <= CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Read port is purely a function of the requested op and current HI/LO.
    always_comb begin
        case (bus.operation)
            OP_MFHI: bus.dataRead = hi_q;
            OP_MFLO: bus.dataRead = lo_q;
            default: bus.dataRead = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_iterative_core.sv
// -----------------------------------------------------------------------------
// tb_mdu_iterative_core : directed self-checking bench for mdu_iterative_core.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mdu_iterative_core;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MFHI  = 4'd1;
    localparam logic [3:0] OP_MFLO  = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd3;
    localparam logic [3:0] OP_MTLO  = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_MULTU = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mdu_if bus ();

    mdu_iterative_core #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Call at a falling edge; returns at the falling edge after the start edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.operation = op;
        bus.operand1  = a;
        bus.operand2  = b;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start     = 1'b0;
        bus.operation = OP_NONE;
    endtask

    // Counts falling edges that see busy high; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles, input logic [63:0] exp_hilo);
        int n;
        issue(op, a, b);
        wait_done(n);
        check_val({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
        check_val({tag, "_hilo"}, {bus.hi, bus.lo}, exp_hilo);
    endtask

    initial begin
        int n;
        bus.operation = OP_NONE;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.start     = 1'b0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check_val("reset_busy", 64'(bus.busy), 64'd0);
        check_val("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Signed multiply: -2 * 3 = -6
        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, MUL_N, 64'hFFFF_FFFF_FFFF_FFFA);
        bus.operation = OP_MFHI;
        #1 check_val("mfhi_read", 64'(bus.dataRead), 64'h0000_0000_FFFF_FFFF);
        bus.operation = OP_MFLO;
        #1 check_val("mflo_read", 64'(bus.dataRead), 64'h0000_0000_FFFF_FFFA);
        bus.operation = OP_NONE;
        #1 check_val("none_read", 64'(bus.dataRead), 64'd0);
        @(negedge clock);

        // Unsigned multiply then back-to-back accumulate
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_N, 64'hFFFF_FFFE_0000_0001);
        run_op("maddu", OP_MADDU, 32'h0000_0001, 32'h0000_0001, MUL_N, 64'hFFFF_FFFE_0000_0002);

        // Signed divide -7 / 2 -> q=-3, r=-1; divide by zero keeps HI/LO
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, DIV_N, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", OP_DIVU, 32'h0000_0007, 32'h0000_0000, DIV_N, 64'hFFFF_FFFF_FFFF_FFFD);

        // Overflow case of signed divide
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 64'h0000_0000_8000_0000);

        // MTHI: single-edge write, no busy
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        check_val("mthi_busy", 64'(bus.busy), 64'd0);
        check_val("mthi_hi", 64'(bus.hi), 64'h0000_0000_1234_5678);
        bus.operation = OP_MFHI;
        #1 check_val("mthi_mfhi", 64'(bus.dataRead), 64'h0000_0000_1234_5678);
        bus.operation = OP_NONE;
        @(negedge clock);

        // Clear accumulator, then MSUB 2*3 and MADD -1*6
        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'h0, 32'h0);
        check_val("mtlo_hilo", {bus.hi, bus.lo}, 64'd0);
        run_op("msub", OP_MSUB, 32'h0000_0002, 32'h0000_0003, MUL_N, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("madd", OP_MADD, 32'hFFFF_FFFF, 32'h0000_0006, MUL_N, 64'hFFFF_FFFF_FFFF_FFF4);

        // Start and operand changes while busy are ignored: 100 / 7 -> q=14, r=2
        issue(OP_DIV, 32'd100, 32'd7);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (n == 3) begin
                bus.operation = OP_MTLO;
                bus.operand1  = 32'h0000_AAAA;
                bus.operand2  = 32'h0000_0001;
                bus.start     = 1'b1;
            end else begin
                bus.operation = OP_NONE;
                bus.start     = 1'b0;
            end
            @(negedge clock);
        end
        bus.operation = OP_NONE;
        bus.start     = 1'b0;
        check_val("div_ignore_busy_cycles", 64'(n), 64'(DIV_N));
        check_val("div_ignore_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

        // Asynchronous reset mid-MULT
        issue(OP_MULT, 32'd5, 32'd5);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_val("areset_busy", 64'(bus.busy), 64'd0);
        check_val("areset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        check_val("post_reset_busy", 64'(bus.busy), 64'd0);
        check_val("post_reset_hilo", {bus.hi, bus.lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_iterative_core.md
Name: mdu_iterative_core

Overview:
- Multi-cycle multiply/divide responder serving the EX stage's start/busy MDU request interface; owns the architectural HI/LO registers.
- EX drives operands, operation and a one-cycle start pulse. It stalls while busy is high and an MDU-using instruction is in EX.
- Reads (MFHI/MFLO) return combinationally on dataRead.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (min 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (min 1)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- operand1  input  32  rs value (dividend / multiplicand / MTHI-MTLO source)
- operand2  input  32  rt value (divisor / multiplier)
- operation  input  4  0 NONE, 1 MFHI, 2 MFLO, 3 MTHI, 4 MTLO, 5 MULT, 6 MULTU, 7 DIV, 8 DIVU, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU, 13-15 treated as NONE
- start  input  1  request strobe, sampled on the clock edge
- busy  output  1  registered; high while an operation is in flight
- dataRead  output  32  combinational: HI when operation=MFHI, LO when MFLO, else 0
- hi  output  32  current HI register (debug/trace)
- lo  output  32  current LO register (debug/trace)

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, HI=0, LO=0, counter=0, pending results=0. Any in-flight operation is discarded; HI/LO do not receive its result.
- FSM states: IDLE, RUN.
- IDLE, start=1:
  - MULT-class or DIV-class: capture the operation and compute the pending {HI,LO} result from the current operands and HI/LO. Load counter with MUL_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
  - MTHI/MTLO: write HI or LO with operand1 at that edge; stay IDLE; busy stays 0.
  - MFHI/MFLO/NONE: no state change.
- RUN: decrement the counter each cycle. When the counter reaches 1, write the pending result to HI/LO at that edge, set busy=0 and return to IDLE.
  - Net timing: busy is high for exactly N cycles, with N = MUL_CYCLES or DIV_CYCLES.
  - HI/LO change at the same edge where busy falls.
- start while busy (RUN) is ignored entirely, including MTHI/MTLO. EX guarantees this never happens; the ignore is required for robustness.
- Back-to-back: start may be asserted in the first cycle busy=0 after completion. It sees the updated HI/LO.
- Arithmetic:
  - MULT: signed 32x32 to 64-bit; {HI,LO}=product.
  - MULTU: unsigned 32x32 to 64-bit; {HI,LO}=product.
  - MADD: {HI,LO} += signed product. MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} -= signed product. MSUBU: {HI,LO} -= unsigned product.
  - All accumulate/subtract results wrap modulo 2^64. The accumulator is the HI/LO value at start.
- Division:
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned equivalent of DIV.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor=0: the op still occupies DIV_CYCLES with busy=1, but HI/LO are left unchanged at completion.
- dataRead:
  - Purely combinational on operation and the HI/LO registers; independent of start and busy.
  - Returns HI/LO as of that cycle; EX is responsible for stalling reads while busy.
- Operands are sampled only at the start edge; later operand changes do not affect the in-flight result.

Test Plan:
- Reset then MULT 0xFFFFFFFE x 0x00000003, start one cycle -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFHI on dataRead gives 0xFFFFFFFF.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001. Then MADDU 1x1 -> LO=0x00000002, HI=0xFFFFFFFE.
- DIV -7 / 2 -> busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> busy for 10 cycles, HI/LO unchanged.
- MTHI 0x12345678 with start -> busy stays 0; HI=0x12345678 at the next edge. MFHI then returns 0x12345678 combinationally.
- During DIV at cycle 3 of busy: pulse start with MTLO 0xAAAA, and change operands -> both ignored. Final LO is the DIV quotient; busy still lasts 10 cycles.
- Assert reset low asynchronously mid-MULT (between edges) -> busy=0, HI=LO=0 immediately. After release, no late HI/LO write occurs.
